// File: rtl/udp_port_steer_if.sv
// UDP header + 64b payload bundles for the port steering block.
//   udp_rx_if : single upstream stream (scalar handshakes)
//   udp_ch_if : NUM_CH downstream channels (one-hot valids, shared data)
interface udp_rx_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    udp_hdr_valid;
  logic                    udp_hdr_ready;
  logic [31:0]             udp_ip_source_ip;
  logic [15:0]             udp_source_port;
  logic [15:0]             udp_dest_port;
  logic [15:0]             udp_length;
  logic [DATA_WIDTH-1:0]   payload_axis_tdata;
  logic [DATA_WIDTH/8-1:0] payload_axis_tkeep;
  logic                    payload_axis_tvalid;
  logic                    payload_axis_tready;
  logic                    payload_axis_tlast;
  logic                    payload_axis_tuser;

  modport master (
    output udp_hdr_valid, udp_ip_source_ip, udp_source_port, udp_dest_port, udp_length,
    output payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
    output payload_axis_tlast, payload_axis_tuser,
    input  udp_hdr_ready, payload_axis_tready
  );
  modport slave (
    input  udp_hdr_valid, udp_ip_source_ip, udp_source_port, udp_dest_port, udp_length,
    input  payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
    input  payload_axis_tlast, payload_axis_tuser,
    output udp_hdr_ready, payload_axis_tready
  );
endinterface

interface udp_ch_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_CH-1:0]       udp_hdr_valid;
  logic [NUM_CH-1:0]       udp_hdr_ready;
  logic [31:0]             udp_ip_source_ip;
  logic [15:0]             udp_source_port;
  logic [15:0]             udp_dest_port;
  logic [15:0]             udp_length;
  logic [DATA_WIDTH-1:0]   payload_axis_tdata;
  logic [DATA_WIDTH/8-1:0] payload_axis_tkeep;
  logic [NUM_CH-1:0]       payload_axis_tvalid;
  logic [NUM_CH-1:0]       payload_axis_tready;
  logic                    payload_axis_tlast;
  logic                    payload_axis_tuser;

  modport master (
    output udp_hdr_valid, udp_ip_source_ip, udp_source_port, udp_dest_port, udp_length,
    output payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
    output payload_axis_tlast, payload_axis_tuser,
    input  udp_hdr_ready, payload_axis_tready
  );
  modport slave (
    input  udp_hdr_valid, udp_ip_source_ip, udp_source_port, udp_dest_port, udp_length,
    input  payload_axis_tdata, payload_axis_tkeep, payload_axis_tvalid,
    input  payload_axis_tlast, payload_axis_tuser,
    output udp_hdr_ready, payload_axis_tready
  );
endinterface

// File: rtl/udp_port_steer.sv
// udp_port_steer: routes each UDP frame to one of NUM_CH channels by destination
// port (lowest enabled matching channel wins) or drops it. Routing decision is
// frozen at header accept, so table/mask edits only affect the next frame.
// Optional: `define UDP_STEER_STATS_EN adds per-channel saturating frame counters.
module udp_port_steer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [16*NUM_CH-1:0]   port_table,
  input  logic [NUM_CH-1:0]      ch_enable,
  udp_rx_if.slave                s,
  udp_ch_if.master               m,
  output logic [CNT_WIDTH-1:0]   drop_count
`ifdef UDP_STEER_STATS_EN
  ,
  output logic [CNT_WIDTH*NUM_CH-1:0] frame_count
`endif
);

  localparam int SELW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [SELW-1:0]      sel_q, sel_d;
  logic [31:0]          ip_q;
  logic [15:0]          sport_q, dport_q, len_q;
  logic [CNT_WIDTH-1:0] drop_q;

  logic                 hit;
  logic [SELW-1:0]      hit_idx;
  logic                 hdr_acc;
  logic                 beat_pay;
  logic                 beat_drop;
  logic [NUM_CH-1:0]    sel_oh;

  // Port match: scan high to low so the lowest enabled match is left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_enable[i] && (port_table[16*i +: 16] == s.udp_dest_port)) begin
        hit     = 1'b1;
        hit_idx = SELW'(i);
      end
    end
  end

  assign sel_oh    = NUM_CH'(1) << sel_q;
  assign hdr_acc   = s.udp_hdr_valid && s.udp_hdr_ready;
  assign beat_pay  = (state_q == S_PAY) && s.payload_axis_tvalid && m.payload_axis_tready[sel_q];
  assign beat_drop = (state_q == S_DROP) && s.payload_axis_tvalid;

  // Frame FSM: header accept decides channel or drop; tlast returns to idle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: if (hdr_acc) begin
        state_d = hit ? S_HDR : S_DROP;
        sel_d   = hit ? hit_idx : sel_q;
      end
      S_HDR:  if (m.udp_hdr_ready[sel_q]) state_d = S_PAY;
      S_PAY:  if (beat_pay && s.payload_axis_tlast) state_d = S_IDLE;
      S_DROP: if (beat_drop && s.payload_axis_tlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, selected channel, captured header and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ip_q    <= '0;
      sport_q <= '0;
      dport_q <= '0;
      len_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (hdr_acc) begin
        ip_q    <= s.udp_ip_source_ip;
        sport_q <= s.udp_source_port;
        dport_q <= s.udp_dest_port;
        len_q   <= s.udp_length;
        if (!hit && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
    end
  end

  // Handshake steering: ready held low while in reset so nothing is accepted.
  always_comb begin
    s.udp_hdr_ready       = (state_q == S_IDLE) && !rst;
    s.payload_axis_tready = 1'b0;
    m.udp_hdr_valid       = '0;
    m.payload_axis_tvalid = '0;
    case (state_q)
      S_HDR:  m.udp_hdr_valid = sel_oh;
      S_PAY: begin
        s.payload_axis_tready = m.payload_axis_tready[sel_q];
        if (s.payload_axis_tvalid) m.payload_axis_tvalid = sel_oh;
      end
      S_DROP: s.payload_axis_tready = 1'b1;
      default: ;
    endcase
  end

  assign m.udp_ip_source_ip   = ip_q;
  assign m.udp_source_port    = sport_q;
  assign m.udp_dest_port      = dport_q;
  assign m.udp_length         = len_q;
  assign m.payload_axis_tdata = s.payload_axis_tdata;
  assign m.payload_axis_tkeep = s.payload_axis_tkeep;
  assign m.payload_axis_tlast = s.payload_axis_tlast;
  assign m.payload_axis_tuser = s.payload_axis_tuser;
  assign drop_count           = drop_q;

`ifdef UDP_STEER_STATS_EN
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] fcnt_q;

  // Per-channel completed-frame counters, bumped on each accepted tlast beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (beat_pay && s.payload_axis_tlast && (sel_q == SELW'(i)) && (fcnt_q[i] != '1))
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
      end
    end
  end

  assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_udp_port_steer.sv
// Scoreboard bench for udp_port_steer: driver pushes expected headers/beats
// computed from the routing rules, negedge monitor pops and compares.
module tb_udp_port_steer;
  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [16*NCH-1:0] port_table;
  logic [NCH-1:0]    ch_enable;
  logic [CW-1:0]     drop_count;
`ifdef UDP_STEER_STATS_EN
  logic [CW*NCH-1:0] frame_count;
`endif

  udp_rx_if #(.DATA_WIDTH(DW))               s_if ();
  udp_ch_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) m_if ();

  udp_port_steer #(.NUM_CH(NCH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .port_table(port_table), .ch_enable(ch_enable),
    .s(s_if.slave), .m(m_if.master), .drop_count(drop_count)
`ifdef UDP_STEER_STATS_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [31:0] ip; logic [15:0] sp, dp, len; } hdr_t;
  typedef struct { int ch; logic [DW-1:0] d; logic [DW/8-1:0] k; logic l, u; } beat_t;

  hdr_t  hq[$];
  beat_t bq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_drop = 0;
  int exp_fc[NCH];
  int rdy_mode = 0;   // 0: all ready, 1: random, 2: pattern 1,0,0,1
  int rdy_cyc  = 0;
  bit gap_en   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference routing: lowest enabled channel whose table entry equals the port.
  function automatic int route(input logic [15:0] dp);
    for (int i = 0; i < NCH; i++)
      if (ch_enable[i] && port_table[16*i +: 16] == dp) return i;
    return -1;
  endfunction

  // Downstream ready generation.
  always @(posedge clk) begin
    #1;
    rdy_cyc++;
    case (rdy_mode)
      0: begin m_if.udp_hdr_ready = '1; m_if.payload_axis_tready = '1; end
      1: begin m_if.udp_hdr_ready = NCH'($urandom); m_if.payload_axis_tready = NCH'($urandom); end
      default: begin
        m_if.udp_hdr_ready = '1;
        m_if.payload_axis_tready = ((rdy_cyc % 4) == 0 || (rdy_cyc % 4) == 3) ? '1 : '0;
      end
    endcase
  end

  // Monitor: compare every downstream handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      logic [NCH-1:0] hv, pv, oh;
      hv = m_if.udp_hdr_valid & m_if.udp_hdr_ready;
      if (hv != 0) begin
        if (hq.size() == 0) chk("hdr_unexpected", hv, 0);
        else begin
          hdr_t h;
          h = hq.pop_front();
          oh = NCH'(1) << h.ch;
          chk("hdr_ch", hv, oh);
          chk("hdr_ip", m_if.udp_ip_source_ip, h.ip);
          chk("hdr_sport", m_if.udp_source_port, h.sp);
          chk("hdr_dport", m_if.udp_dest_port, h.dp);
          chk("hdr_len", m_if.udp_length, h.len);
        end
      end
      if (m_if.payload_axis_tvalid != 0) begin
        if (bq.size() == 0) chk("pay_unexpected", m_if.payload_axis_tvalid, 0);
        else begin
          oh = NCH'(1) << bq[0].ch;
          chk("pay_valid_ch", m_if.payload_axis_tvalid, oh);
          pv = m_if.payload_axis_tvalid & m_if.payload_axis_tready;
          if (pv != 0) begin
            beat_t b;
            b = bq.pop_front();
            chk("pay_data", m_if.payload_axis_tdata, b.d);
            chk("pay_keep", m_if.payload_axis_tkeep, b.k);
            chk("pay_last", m_if.payload_axis_tlast, b.l);
            chk("pay_user", m_if.payload_axis_tuser, b.u);
          end
        end
      end
    end
  end

  // Send one frame. chg_at >= 0: rewrite port_table[0] to 80 before that beat.
  // rst_at >= 0: assert reset while that beat is presented and abandon the frame.
  task automatic send_frame(input logic [15:0] dp, input int nb, input int chg_at, input int rst_at);
    int r, t;
    logic [NCH-1:0] oh;
    s_if.udp_hdr_valid    = 1'b1;
    s_if.udp_ip_source_ip = $urandom;
    s_if.udp_source_port  = 16'($urandom);
    s_if.udp_dest_port    = dp;
    s_if.udp_length       = 16'(8 + nb * 8);
    t = 0;
    forever begin
      @(negedge clk);
      if (s_if.udp_hdr_ready) break;
      if (++t > 200) begin chk("timeout_hdr", 1, 0); s_if.udp_hdr_valid = 1'b0; return; end
    end
    r = route(dp);
    if (r < 0) exp_drop++;
    else hq.push_back('{r, s_if.udp_ip_source_ip, s_if.udp_source_port, dp, s_if.udp_length});
    @(posedge clk); #1;
    s_if.udp_hdr_valid = 1'b0;
    s_if.udp_dest_port = 16'($urandom);
    @(negedge clk);
    oh = (r < 0) ? '0 : NCH'(1) << r;
    chk("hdr_valid_lat1", m_if.udp_hdr_valid, oh);
    if (r < 0) chk("drop_count", drop_count, CW'(exp_drop));
    @(posedge clk); #1;
    for (int b = 0; b < nb; b++) begin
      if (b == chg_at) port_table[15:0] = 16'd80;
      if (gap_en && ($urandom % 3 == 0)) begin
        s_if.payload_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_if.payload_axis_tvalid = 1'b1;
      s_if.payload_axis_tdata  = {$urandom, $urandom};
      s_if.payload_axis_tkeep  = (b == nb - 1) ? 8'h0f : 8'hff;
      s_if.payload_axis_tlast  = (b == nb - 1);
      s_if.payload_axis_tuser  = 1'($urandom);
      if (r >= 0)
        bq.push_back('{r, s_if.payload_axis_tdata, s_if.payload_axis_tkeep,
                       s_if.payload_axis_tlast, s_if.payload_axis_tuser});
      if (b == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_hdr_valid_zero", m_if.udp_hdr_valid, 0);
        chk("rst_pay_valid_zero", m_if.payload_axis_tvalid, 0);
        chk("rst_hdr_ready_low", s_if.udp_hdr_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        s_if.payload_axis_tvalid = 1'b0;
        hq.delete();
        bq.delete();
        exp_drop = 0;
        for (int i = 0; i < NCH; i++) exp_fc[i] = 0;
        return;
      end
      t = 0;
      forever begin
        @(negedge clk);
        if (r < 0) chk("drop_tready", s_if.payload_axis_tready, 1);
        if (s_if.payload_axis_tready) break;
        if (++t > 200) begin chk("timeout_beat", 1, 0); s_if.payload_axis_tvalid = 1'b0; return; end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    s_if.payload_axis_tvalid = 1'b0;
    s_if.payload_axis_tlast  = 1'b0;
    if (r >= 0) exp_fc[r]++;
    @(negedge clk);
    chk("idle_after_tlast", s_if.udp_hdr_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic set_tbl(input logic [15:0] p0, p1, p2, p3, input logic [NCH-1:0] en);
    port_table = {p3, p2, p1, p0};
    ch_enable  = en;
  endtask

  initial begin
    int t;
    s_if.udp_hdr_valid = 1'b0;
    s_if.udp_ip_source_ip = '0; s_if.udp_source_port = '0;
    s_if.udp_dest_port = '0; s_if.udp_length = '0;
    s_if.payload_axis_tvalid = 1'b0; s_if.payload_axis_tdata = '0;
    s_if.payload_axis_tkeep = '0; s_if.payload_axis_tlast = 1'b0; s_if.payload_axis_tuser = 1'b0;
    m_if.udp_hdr_ready = '1; m_if.payload_axis_tready = '1;
    for (int i = 0; i < NCH; i++) exp_fc[i] = 0;
    set_tbl(16'd1234, 16'd5678, 16'd0, 16'd0, 4'b0011);

    #12;
    chk("reset_hdr_ready", s_if.udp_hdr_ready, 0);
    chk("reset_hdr_valid", m_if.udp_hdr_valid, 0);
    chk("reset_pay_valid", m_if.payload_axis_tvalid, 0);
    chk("reset_dport", m_if.udp_dest_port, 0);
    chk("reset_ip", m_if.udp_ip_source_ip, 0);
    chk("reset_drop", drop_count, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("hdr_ready_after_reset", s_if.udp_hdr_ready, 1);
    @(posedge clk); #1;

    // routed to ch1, then dropped, then duplicate port lowest-index wins
    send_frame(16'd5678, 3, -1, -1);
    chk("drop_zero", drop_count, 0);
    send_frame(16'd9999, 3, -1, -1);
    chk("drop_one", drop_count, 1);
    set_tbl(16'd1234, 16'd5678, 16'd1234, 16'd0, 4'b0101);
    send_frame(16'd1234, 2, -1, -1);

    // backpressure pattern on the selected channel
    set_tbl(16'd1234, 16'd5678, 16'd0, 16'd0, 4'b0011);
    rdy_mode = 2;
    send_frame(16'd5678, 4, -1, -1);
    rdy_mode = 0;

    // table change mid-frame: current frame stays on ch0, next 1234 frame drops
    send_frame(16'd1234, 3, 1, -1);
    send_frame(16'd1234, 2, -1, -1);
    chk("drop_after_tbl_change", drop_count, CW'(exp_drop));

    // all channels disabled
    set_tbl(16'd1, 16'd2, 16'd3, 16'd4, 4'b0000);
    send_frame(16'd2, 1, -1, -1);

    // random traffic
    rdy_mode = 1;
    gap_en = 1;
    for (int f = 0; f < 40; f++) begin
      set_tbl(16'($urandom_range(1, 5)), 16'($urandom_range(1, 5)),
              16'($urandom_range(1, 5)), 16'($urandom_range(1, 5)), NCH'($urandom));
      send_frame(16'($urandom_range(1, 6)), $urandom_range(1, 5), -1, -1);
    end
    chk("drop_random", drop_count, CW'(exp_drop));

`ifdef UDP_STEER_STATS_EN
    for (int i = 0; i < NCH; i++) chk("frame_count", frame_count[CW*i +: CW], CW'(exp_fc[i]));
`endif

    t = 0;
    while ((hq.size() != 0 || bq.size() != 0) && t < 100) begin @(negedge clk); t++; end
    chk("sb_hdr_empty", hq.size(), 0);
    chk("sb_beat_empty", bq.size(), 0);

    // reset while a frame is in PAYLOAD
    rdy_mode = 0;
    gap_en = 0;
    set_tbl(16'd1234, 16'd5678, 16'd0, 16'd0, 4'b0011);
    send_frame(16'd1234, 4, -1, 2);
    @(negedge clk);
    chk("hdr_ready_after_midrst", s_if.udp_hdr_ready, 1);
    chk("drop_after_midrst", drop_count, 0);
    chk("dport_after_midrst", m_if.udp_dest_port, 0);
`ifdef UDP_STEER_STATS_EN
    chk("frame_count_after_midrst", frame_count, 0);
`endif
    @(posedge clk); #1;
    send_frame(16'd5678, 2, -1, -1);
    t = 0;
    while ((hq.size() != 0 || bq.size() != 0) && t < 100) begin @(negedge clk); t++; end
    chk("sb_final_empty", hq.size() + bq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
